// File: rtl/popcnt_accumulator.sv
// Beat-serial popcount of fingerprint vectors A, B and A&B, feeding the Tanimoto comparator.
// Optional framing check of i_Last against the beat counter: define POPCNT_LAST_CHECK_EN.
module popcnt_accumulator #(
    parameter int VECTOR_WIDTH = 35,
    parameter int BUS_WIDTH    = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_Valid,
    input  logic [BUS_WIDTH-1:0]              i_VecA,
    input  logic [BUS_WIDTH-1:0]              i_VecB,
    input  logic                              i_Last,
    input  logic                              i_Clr,
    output logic                              o_Valid,
    output logic [$clog2(VECTOR_WIDTH+1)-1:0] o_CntA,
    output logic [$clog2(VECTOR_WIDTH+1)-1:0] o_CntB,
    output logic [$clog2(VECTOR_WIDTH+1)-1:0] o_CntC,
    output logic                              o_Err
);

    localparam int BEATS     = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int LAST_BITS = VECTOR_WIDTH - (BEATS - 1) * BUS_WIDTH;
    localparam int CNT_WIDTH = $clog2(VECTOR_WIDTH + 1);
    localparam int PC_W      = $clog2(BUS_WIDTH + 1);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BUS_WIDTH-1:0] LAST_MASK = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - LAST_BITS);

    function automatic logic [PC_W-1:0] popcount(input logic [BUS_WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [BEAT_W-1:0]    beat_cnt;
    logic                 is_last_p0;
    logic [BUS_WIDTH-1:0] mask_p0;
    logic [BUS_WIDTH-1:0] a_msk_p0;
    logic [BUS_WIDTH-1:0] b_msk_p0;

    logic [PC_W-1:0]      cnt_a_p1;
    logic [PC_W-1:0]      cnt_b_p1;
    logic [PC_W-1:0]      cnt_c_p1;
    logic                 vld_p1;
    logic                 last_p1;

    logic [CNT_WIDTH-1:0] acc_a;
    logic [CNT_WIDTH-1:0] acc_b;
    logic [CNT_WIDTH-1:0] acc_c;

    // Stage 0: beat position and padding mask for the final beat
    assign is_last_p0 = (beat_cnt == BEAT_W'(BEATS - 1));
    assign mask_p0    = is_last_p0 ? LAST_MASK : {BUS_WIDTH{1'b1}};
    assign a_msk_p0   = i_VecA & mask_p0;
    assign b_msk_p0   = i_VecB & mask_p0;

    // Stage 1: per-beat popcounts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            cnt_a_p1 <= '0;
            cnt_b_p1 <= '0;
            cnt_c_p1 <= '0;
        end else if (i_Clr) begin
            beat_cnt <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= i_Valid;
            if (i_Valid) begin
                beat_cnt <= is_last_p0 ? '0 : beat_cnt + BEAT_W'(1);
                last_p1  <= is_last_p0;
                cnt_a_p1 <= popcount(a_msk_p0);
                cnt_b_p1 <= popcount(b_msk_p0);
                cnt_c_p1 <= popcount(a_msk_p0 & b_msk_p0);
            end
        end
    end

    // Stage 2: accumulate; on the last beat publish and restart with no bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_a   <= '0;
            acc_b   <= '0;
            acc_c   <= '0;
            o_Valid <= 1'b0;
            o_CntA  <= '0;
            o_CntB  <= '0;
            o_CntC  <= '0;
        end else if (i_Clr) begin
            acc_a   <= '0;
            acc_b   <= '0;
            acc_c   <= '0;
            o_Valid <= 1'b0;
        end else begin
            o_Valid <= vld_p1 && last_p1;
            if (vld_p1) begin
                if (last_p1) begin
                    o_CntA <= acc_a + CNT_WIDTH'(cnt_a_p1);
                    o_CntB <= acc_b + CNT_WIDTH'(cnt_b_p1);
                    o_CntC <= acc_c + CNT_WIDTH'(cnt_c_p1);
                    acc_a  <= '0;
                    acc_b  <= '0;
                    acc_c  <= '0;
                end else begin
                    acc_a <= acc_a + CNT_WIDTH'(cnt_a_p1);
                    acc_b <= acc_b + CNT_WIDTH'(cnt_b_p1);
                    acc_c <= acc_c + CNT_WIDTH'(cnt_c_p1);
                end
            end
        end
    end

`ifdef POPCNT_LAST_CHECK_EN
    // Framing error is sticky and purely diagnostic; counting follows beat_cnt regardless
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_Err <= 1'b0;
        end else if (i_Clr) begin
            o_Err <= 1'b0;
        end else if (i_Valid && (i_Last != is_last_p0)) begin
            o_Err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = i_Last;
    assign o_Err       = 1'b0;
`endif

endmodule

// File: tb/tb_popcnt_accumulator.sv
// Bench for popcnt_accumulator: table vectors, corner sequences and random traffic
// against a whole-vector reference model. Honours POPCNT_LAST_CHECK_EN.
module tb_popcnt_accumulator;

    localparam int VW    = 35;
    localparam int BW    = 20;
    localparam int BEATS = (VW + BW - 1) / BW;
    localparam int CW    = $clog2(VW + 1);

    logic          clk;
    logic          rst;
    logic          i_Valid;
    logic [BW-1:0] i_VecA;
    logic [BW-1:0] i_VecB;
    logic          i_Last;
    logic          i_Clr;
    logic          o_Valid;
    logic [CW-1:0] o_CntA;
    logic [CW-1:0] o_CntB;
    logic [CW-1:0] o_CntC;
    logic          o_Err;

    popcnt_accumulator #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .i_Valid(i_Valid), .i_VecA(i_VecA), .i_VecB(i_VecB),
        .i_Last(i_Last), .i_Clr(i_Clr), .o_Valid(o_Valid), .o_CntA(o_CntA),
        .o_CntB(o_CntB), .o_CntC(o_CntC), .o_Err(o_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] a0, b0, a1, b1;
        int            ea, eb, ec;
    } vec_t;

    typedef struct {
        int cyc;
        int a, b, c;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: whole-vector view of the beat stream
    logic [BW-1:0] pa [BEATS];
    logic [BW-1:0] pb [BEATS];
    int            pn = 0;
    exp_t          q[$];
    int            last_a = 0, last_b = 0, last_c = 0;
    bit            m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int                    e;
        logic [BEATS*BW-1:0]   va, vb;
        exp_t                  x;
        e = cyc + 1;
        if (!rst) begin
            pn = 0;
            q.delete();
            last_a = 0; last_b = 0; last_c = 0;
            m_err = 1'b0;
        end else if (i_Clr) begin
            pn = 0;
            m_err = 1'b0;
            while (q.size() > 0 && q[q.size()-1].cyc == e) void'(q.pop_back());
        end else if (i_Valid) begin
`ifdef POPCNT_LAST_CHECK_EN
            if (i_Last != (pn == BEATS - 1)) m_err = 1'b1;
`endif
            pa[pn] = i_VecA;
            pb[pn] = i_VecB;
            pn++;
            if (pn == BEATS) begin
                for (int k = 0; k < BEATS; k++) begin
                    va[k*BW +: BW] = pa[k];
                    vb[k*BW +: BW] = pb[k];
                end
                x.cyc = e + 1;
                x.a   = $countones(va[VW-1:0]);
                x.b   = $countones(vb[VW-1:0]);
                x.c   = $countones(va[VW-1:0] & vb[VW-1:0]);
                q.push_back(x);
                pn = 0;
            end
        end
    endtask

    task automatic check_cycle();
        if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("m_valid", 32'(o_Valid), 32'd1);
            chk("m_cnt_a", 32'(o_CntA), 32'(q[0].a));
            chk("m_cnt_b", 32'(o_CntB), 32'(q[0].b));
            chk("m_cnt_c", 32'(o_CntC), 32'(q[0].c));
            last_a = q[0].a; last_b = q[0].b; last_c = q[0].c;
            void'(q.pop_front());
        end else begin
            chk("m_idle_valid", 32'(o_Valid), 32'd0);
            chk("m_hold_a", 32'(o_CntA), 32'(last_a));
            chk("m_hold_b", 32'(o_CntB), 32'(last_b));
            chk("m_hold_c", 32'(o_CntC), 32'(last_c));
        end
        chk("m_err", 32'(o_Err), 32'(m_err));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic last);
        i_Valid = 1'b1;
        i_VecA  = a;
        i_VecB  = b;
        i_Last  = last;
        tick();
        i_Valid = 1'b0;
        i_Last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_VecA = BW'($urandom);
            i_VecB = BW'($urandom);
            tick();
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && o_Valid !== 1'b1; i++) tick();
        chk("pulse_seen", 32'(o_Valid), 32'd1);
    endtask

    vec_t tbl[5];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic exp_err;
        tbl[0] = '{20'hFFFFF, 20'h00000, 20'hFFFFF, 20'h00000, 35, 0, 0};
        tbl[1] = '{20'h0000F, 20'h000FF, 20'h00007, 20'h00001, 7, 9, 5};
        tbl[2] = '{20'h00001, 20'h00001, 20'h00000, 20'h00000, 1, 1, 1};
        tbl[3] = '{20'hAAAAA, 20'hFFFFF, 20'h55555, 20'hFFFFF, 18, 35, 18};
        tbl[4] = '{20'h00000, 20'h00000, 20'h07FFF, 20'hF8000, 15, 0, 0};

        rst = 1'b1; i_Valid = 1'b0; i_VecA = '0; i_VecB = '0; i_Last = 1'b0; i_Clr = 1'b0;
        #3 rst = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            i_Valid = 1'($urandom); i_VecA = BW'($urandom); i_VecB = BW'($urandom);
            i_Last = 1'($urandom); i_Clr = 1'($urandom);
            tick();
            chk("rst_valid", 32'(o_Valid), 32'd0);
            chk("rst_cnt_a", 32'(o_CntA), 32'd0);
            chk("rst_err", 32'(o_Err), 32'd0);
        end
        i_Valid = 1'b0; i_Last = 1'b0; i_Clr = 1'b0;
        rst = 1'b1;
        idle(2);

        // Table-driven vectors
        for (int t = 0; t < 5; t++) begin
            send_beat(tbl[t].a0, tbl[t].b0, 1'b0);
            send_beat(tbl[t].a1, tbl[t].b1, 1'b1);
            chk("tbl_early", 32'(o_Valid), 32'd0);
            tick();
            chk("tbl_valid", 32'(o_Valid), 32'd1);
            chk("tbl_cnt_a", 32'(o_CntA), 32'(tbl[t].ea));
            chk("tbl_cnt_b", 32'(o_CntB), 32'(tbl[t].eb));
            chk("tbl_cnt_c", 32'(o_CntC), 32'(tbl[t].ec));
            tick();
            chk("tbl_pulse_end", 32'(o_Valid), 32'd0);
        end

        // Back-to-back vectors at full rate
        send_beat(20'h0000F, 20'h000FF, 1'b0);
        send_beat(20'h00007, 20'h00001, 1'b1);
        send_beat(20'h00001, 20'h00001, 1'b0);
        chk("b2b_v1", 32'(o_Valid), 32'd1);
        chk("b2b_a1", 32'(o_CntA), 32'd7);
        send_beat(20'h00000, 20'h00000, 1'b1);
        chk("b2b_gap", 32'(o_Valid), 32'd0);
        tick();
        chk("b2b_v2", 32'(o_Valid), 32'd1);
        chk("b2b_a2", 32'(o_CntA), 32'd1);
        chk("b2b_c2", 32'(o_CntC), 32'd1);
        idle(2);

        // Same pair with idle gaps between beats
        send_beat(20'h0000F, 20'h000FF, 1'b0); idle(3);
        send_beat(20'h00007, 20'h00001, 1'b1);
        wait_valid(5);
        chk("gap_a1", 32'(o_CntA), 32'd7);
        chk("gap_b1", 32'(o_CntB), 32'd9);
        chk("gap_c1", 32'(o_CntC), 32'd5);
        idle(3);
        send_beat(20'h00001, 20'h00001, 1'b0); idle(3);
        send_beat(20'h00000, 20'h00000, 1'b1);
        wait_valid(5);
        chk("gap_a2", 32'(o_CntA), 32'd1);
        chk("gap_b2", 32'(o_CntB), 32'd1);
        idle(2);

        // Abort a partial vector with i_Clr colliding with a beat
        send_beat(20'hFFFFF, 20'h00000, 1'b0);
        i_Clr = 1'b1; i_Valid = 1'b1; i_VecA = 20'hFFFFF; i_VecB = 20'h0;
        tick();
        i_Clr = 1'b0; i_Valid = 1'b0;
        send_beat(20'h00003, 20'h00000, 1'b0);
        send_beat(20'h00000, 20'h00000, 1'b1);
        wait_valid(4);
        chk("clr_a", 32'(o_CntA), 32'd2);
        chk("clr_b", 32'(o_CntB), 32'd0);
        idle(2);

        // i_Clr kills a final beat held in stage 1
        send_beat(20'h000FF, 20'h000FF, 1'b0);
        send_beat(20'h00001, 20'h00001, 1'b1);
        i_Clr = 1'b1;
        tick();
        i_Clr = 1'b0;
        chk("kill_valid", 32'(o_Valid), 32'd0);
        chk("kill_hold_a", 32'(o_CntA), 32'd2);
        idle(3);

        // Reset mid-vector
        send_beat(20'hFFFFF, 20'hFFFFF, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        send_beat(20'h00003, 20'h00000, 1'b0);
        send_beat(20'h00000, 20'h00000, 1'b1);
        wait_valid(4);
        chk("rstmid_a", 32'(o_CntA), 32'd2);
        chk("rstmid_b", 32'(o_CntB), 32'd0);
        idle(2);

        // Framing error: i_Last on beat 0
`ifdef POPCNT_LAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        send_beat(20'h0000F, 20'h000FF, 1'b1);
        chk("err_set", 32'(o_Err), 32'(exp_err));
        send_beat(20'h00007, 20'h00001, 1'b1);
        wait_valid(4);
        chk("err_cnt_a", 32'(o_CntA), 32'd7);
        chk("err_cnt_c", 32'(o_CntC), 32'd5);
        idle(3);
        chk("err_sticky", 32'(o_Err), 32'(exp_err));
        i_Clr = 1'b1;
        tick();
        i_Clr = 1'b0;
        chk("err_clr", 32'(o_Err), 32'd0);
        idle(2);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            i_Valid = ($urandom_range(0, 99) < 60);
            i_VecA  = BW'($urandom);
            i_VecB  = BW'($urandom);
            i_Last  = (pn == BEATS - 1) ^ ($urandom_range(0, 19) == 0);
            i_Clr   = ($urandom_range(0, 99) < 3);
            tick();
        end
        i_Valid = 1'b0; i_Clr = 1'b0; i_Last = 1'b0;
        idle(4);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
